// File: rtl/vdma_axi4s_to_axi4_core_if.sv
// Bus bundle for the VDMA stream-to-memory write core: AXI4 write channels (AW/W/B)
// plus the 32-bit AXI4-Stream video input. "master" is the core's view, "slave" the far side.
interface vdma_axi4s_to_axi4_core_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic [5:0]            m_axi4_awid;
    logic [ADDR_WIDTH-1:0] m_axi4_awaddr;
    logic [LEN_WIDTH-1:0]  m_axi4_awlen;
    logic [2:0]            m_axi4_awsize;
    logic [1:0]            m_axi4_awburst;
    logic [3:0]            m_axi4_awcache;
    logic                  m_axi4_awlock;
    logic [2:0]            m_axi4_awprot;
    logic [3:0]            m_axi4_awqos;
    logic [3:0]            m_axi4_awregion;
    logic                  m_axi4_awvalid;
    logic                  m_axi4_awready;
    logic [31:0]           m_axi4_wdata;
    logic [3:0]            m_axi4_wstrb;
    logic                  m_axi4_wlast;
    logic                  m_axi4_wvalid;
    logic                  m_axi4_wready;
    logic                  m_axi4_bvalid;
    logic                  m_axi4_bready;
    logic                  s_axi4s_tuser;
    logic [31:0]           s_axi4s_tdata;
    logic                  s_axi4s_tvalid;
    logic                  s_axi4s_tready;

    modport master (
        output m_axi4_awid, m_axi4_awaddr, m_axi4_awlen, m_axi4_awsize, m_axi4_awburst,
        output m_axi4_awcache, m_axi4_awlock, m_axi4_awprot, m_axi4_awqos, m_axi4_awregion,
        output m_axi4_awvalid, m_axi4_wdata, m_axi4_wstrb, m_axi4_wlast, m_axi4_wvalid,
        output m_axi4_bready, s_axi4s_tready,
        input  m_axi4_awready, m_axi4_wready, m_axi4_bvalid,
        input  s_axi4s_tuser, s_axi4s_tdata, s_axi4s_tvalid
    );

    modport slave (
        input  m_axi4_awid, m_axi4_awaddr, m_axi4_awlen, m_axi4_awsize, m_axi4_awburst,
        input  m_axi4_awcache, m_axi4_awlock, m_axi4_awprot, m_axi4_awqos, m_axi4_awregion,
        input  m_axi4_awvalid, m_axi4_wdata, m_axi4_wstrb, m_axi4_wlast, m_axi4_wvalid,
        input  m_axi4_bready, s_axi4s_tready,
        output m_axi4_awready, m_axi4_wready, m_axi4_bvalid,
        output s_axi4s_tuser, s_axi4s_tdata, s_axi4s_tvalid
    );
endinterface

// File: rtl/vdma_axi4s_to_axi4_core.sv
// VDMA write core: writes one video frame from an AXI4-Stream into memory as
// fixed-length AXI4 INCR bursts, line by line with a programmable stride.
module vdma_axi4s_to_axi4_core #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int INDEX_WIDTH = 8,
    parameter int H_WIDTH     = 12,
    parameter int V_WIDTH     = 12
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   ctl_enable,
    input  logic                   ctl_update,
    output logic                   ctl_busy,
    output logic [INDEX_WIDTH-1:0] ctl_index,
    input  logic [ADDR_WIDTH-1:0]  param_addr,
    input  logic [ADDR_WIDTH-1:0]  param_stride,
    input  logic [H_WIDTH-1:0]     param_width,
    input  logic [V_WIDTH-1:0]     param_height,
    input  logic [LEN_WIDTH-1:0]   param_awlen,
    vdma_axi4s_to_axi4_core_if.master bus
);
    localparam int CNT_WIDTH = H_WIDTH + V_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_SYNC, W_DATA, W_DONE} w_state_t;

    logic                   busy_r;
    logic [INDEX_WIDTH-1:0] index_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [ADDR_WIDTH-1:0]  stride_r;
    logic [H_WIDTH-1:0]     width_r;
    logic [V_WIDTH-1:0]     height_r;
    logic [LEN_WIDTH-1:0]   awlen_r;
    logic                   awvalid_r;
    logic                   aw_pend_r;
    logic [ADDR_WIDTH-1:0]  awaddr_r;
    logic [ADDR_WIDTH-1:0]  line_base_r;
    logic [H_WIDTH-1:0]     aw_x_r;
    logic [V_WIDTH-1:0]     aw_y_r;
    logic [3:0]             credit_r;
    w_state_t               w_state_r;
    logic [LEN_WIDTH-1:0]   w_beat_r;
    logic [H_WIDTH-1:0]     w_x_r;
    logic [V_WIDTH-1:0]     w_y_r;
    logic [CNT_WIDTH-1:0]   aw_cnt_r;
    logic [CNT_WIDTH-1:0]   b_cnt_r;

    logic                  start_s;
    logic [ADDR_WIDTH-1:0] start_addr_s;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  w_burst_s;
    logic                  b_hs_s;
    logic                  credit_ok_s;
    logic [3:0]            credit_next_s;
    logic [H_WIDTH-1:0]    aw_x_next_s;
    logic                  line_end_s;
    logic                  frame_end_s;
    logic                  aw_pend_next_s;
    logic [ADDR_WIDTH-1:0] burst_bytes_s;
    logic                  tready_s;
    logic                  wvalid_s;
    logic                  wlast_s;

    assign start_s        = ~busy_r & ctl_enable;
    assign start_addr_s   = ctl_update ? param_addr : addr_r;
    assign aw_hs_s        = awvalid_r & bus.m_axi4_awready;
    assign w_hs_s         = wvalid_s & bus.m_axi4_wready;
    assign w_burst_s      = w_hs_s & wlast_s;
    assign b_hs_s         = busy_r & bus.m_axi4_bvalid;
    assign credit_ok_s    = (credit_r != 4'd0);
    assign aw_x_next_s    = aw_x_r + H_WIDTH'(awlen_r) + H_WIDTH'(1);
    assign line_end_s     = (aw_x_next_s == width_r);
    assign frame_end_s    = line_end_s && (aw_y_r == height_r - V_WIDTH'(1));
    assign aw_pend_next_s = aw_pend_r & ~(aw_hs_s & frame_end_s);
    assign burst_bytes_s  = (ADDR_WIDTH'(awlen_r) + ADDR_WIDTH'(1)) << 2'd2;

    // Credit = addresses issued minus data bursts finished; simultaneous events cancel.
    always_comb begin
        credit_next_s = credit_r;
        case ({aw_hs_s, w_burst_s})
            2'b10:   credit_next_s = credit_r + 4'd1;
            2'b01:   credit_next_s = credit_r - 4'd1;
            default: credit_next_s = credit_r;
        endcase
    end

    // Stream/W steering; in SYNC the tuser beat is left on the bus so it becomes pixel 0.
    always_comb begin
        tready_s = 1'b0;
        wvalid_s = 1'b0;
        wlast_s  = 1'b0;
        case (w_state_r)
            W_SYNC: begin
                tready_s = ~bus.s_axi4s_tuser;
            end
            W_DATA: begin
                wvalid_s = bus.s_axi4s_tvalid & credit_ok_s;
                tready_s = bus.m_axi4_wready & credit_ok_s;
                wlast_s  = (w_beat_r == awlen_r);
            end
            default: begin
                tready_s = 1'b0;
                wvalid_s = 1'b0;
                wlast_s  = 1'b0;
            end
        endcase
    end

    // Frame control, AW address generator, W beat tracking and B completion count.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            busy_r      <= 1'b0;
            index_r     <= '0;
            addr_r      <= '0;
            stride_r    <= '0;
            width_r     <= '0;
            height_r    <= '0;
            awlen_r     <= '0;
            awvalid_r   <= 1'b0;
            aw_pend_r   <= 1'b0;
            awaddr_r    <= '0;
            line_base_r <= '0;
            aw_x_r      <= '0;
            aw_y_r      <= '0;
            credit_r    <= 4'd0;
            w_state_r   <= W_IDLE;
            w_beat_r    <= '0;
            w_x_r       <= '0;
            w_y_r       <= '0;
            aw_cnt_r    <= '0;
            b_cnt_r     <= '0;
        end else if (start_s) begin
            busy_r      <= 1'b1;
            index_r     <= index_r + INDEX_WIDTH'(1);
            if (ctl_update) begin
                addr_r   <= param_addr;
                stride_r <= param_stride;
                width_r  <= param_width;
                height_r <= param_height;
                awlen_r  <= param_awlen;
            end
            awvalid_r   <= 1'b1;
            aw_pend_r   <= 1'b1;
            awaddr_r    <= start_addr_s;
            line_base_r <= start_addr_s;
            aw_x_r      <= '0;
            aw_y_r      <= '0;
            credit_r    <= 4'd0;
            w_state_r   <= W_SYNC;
            w_beat_r    <= '0;
            w_x_r       <= '0;
            w_y_r       <= '0;
            aw_cnt_r    <= '0;
            b_cnt_r     <= '0;
        end else begin
            credit_r  <= credit_next_s;
            aw_pend_r <= aw_pend_next_s;
            // Once raised, awvalid stays up until accepted; credit can only fall meanwhile.
            awvalid_r <= (awvalid_r & ~bus.m_axi4_awready) |
                         (aw_pend_next_s & (credit_next_s != 4'd15));
            if (aw_hs_s) begin
                aw_cnt_r <= aw_cnt_r + CNT_WIDTH'(1);
                if (line_end_s) begin
                    aw_x_r      <= '0;
                    aw_y_r      <= aw_y_r + V_WIDTH'(1);
                    line_base_r <= line_base_r + stride_r;
                    awaddr_r    <= line_base_r + stride_r;
                end else begin
                    aw_x_r   <= aw_x_next_s;
                    awaddr_r <= awaddr_r + burst_bytes_s;
                end
            end
            case (w_state_r)
                W_SYNC: begin
                    if (bus.s_axi4s_tvalid && bus.s_axi4s_tuser) begin
                        w_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        w_beat_r <= wlast_s ? '0 : w_beat_r + LEN_WIDTH'(1);
                        if (w_x_r == width_r - H_WIDTH'(1)) begin
                            w_x_r <= '0;
                            w_y_r <= w_y_r + V_WIDTH'(1);
                            if (w_y_r == height_r - V_WIDTH'(1)) begin
                                w_state_r <= W_DONE;
                            end
                        end else begin
                            w_x_r <= w_x_r + H_WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
            if (b_hs_s) begin
                b_cnt_r <= b_cnt_r + CNT_WIDTH'(1);
            end
            if (busy_r && !aw_pend_r && (w_state_r == W_DONE) && (b_cnt_r == aw_cnt_r)) begin
                busy_r    <= 1'b0;
                w_state_r <= W_IDLE;
            end
        end
    end

    assign ctl_busy             = busy_r;
    assign ctl_index            = index_r;
    assign bus.m_axi4_awid      = 6'd0;
    assign bus.m_axi4_awaddr    = awaddr_r;
    assign bus.m_axi4_awlen     = awlen_r;
    assign bus.m_axi4_awsize    = 3'b010;
    assign bus.m_axi4_awburst   = 2'b01;
    assign bus.m_axi4_awcache   = 4'b0001;
    assign bus.m_axi4_awlock    = 1'b0;
    assign bus.m_axi4_awprot    = 3'b000;
    assign bus.m_axi4_awqos     = 4'd0;
    assign bus.m_axi4_awregion  = 4'd0;
    assign bus.m_axi4_awvalid   = awvalid_r;
    assign bus.m_axi4_wdata     = bus.s_axi4s_tdata;
    assign bus.m_axi4_wstrb     = 4'b1111;
    assign bus.m_axi4_wlast     = wlast_s;
    assign bus.m_axi4_wvalid    = wvalid_s;
    assign bus.m_axi4_bready    = busy_r;
    assign bus.s_axi4s_tready   = tready_s;
endmodule
